alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Control sequencer for the mini CPU datapath's register-to-register ALU instructions. It accepts one decoded instruction (opcode plus Ra/Rb/Rc fields) and drives the datapath strobes cycle by cycle: register out-enables, Y load, Z load, Z read-back, register and HI/LO write. It sits between the instruction decoder and the data_path control inputs, replacing hand-driven strobe sequences.

## Interface
- No parameters. Register count is fixed at 16, opcode width at 5.
- Clock  in  1  datapath clock; all state changes on rising edge
- clear  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- op  in  5  ALU opcode; sampled when start is accepted
- ra, rb, rc  in  4 each  destination, source A, source B; sampled when start is accepted
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse at instruction completion
- illegal  out  1  one-cycle pulse, coincident with done, for an unsupported op
- alu_op  out  5  opcode presented to the ALU; latched value held from T_EXEC through DONE, 0 otherwise
- Rout  out  16  one-hot register out-enable (bit n = Rn out)
- Rin  out  16  one-hot register write-enable
- Yin, ZHighin, Zlowin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes

## Operation
- States: IDLE, T_Y, T_EXEC, T_ZLO, T_ZHI, DONE.
- IDLE + start: latch op/ra/rb/rc. Next state depends on the op class:
  - binary: T_Y
  - unary (NEG, NOT): T_EXEC
  - illegal: DONE with illegal=1
- T_Y: Rout[rb]=1, Yin=1. Next state T_EXEC.
- T_EXEC: ZHighin=1, Zlowin=1, alu_op=op.
  - Rout[rc]=1 for binary ops; Rout[rb]=1 for unary ops.
  - Next state T_ZLO.
- T_ZLO: Zlowout=1.
  - MUL/DIV: LOin=1, next state T_ZHI.
  - All other ops: Rin[ra]=1, next state DONE.
- T_ZHI: Zhighout=1, HIin=1. Next state DONE.
- DONE: done=1. Next state IDLE.
- Strobes not named in a state are 0. At most one Rout bit and at most one Rin bit are high in any cycle.
- ra==rb or ra==rc is legal. Writeback happens in T_ZLO, after the operands were consumed.
- start while not IDLE is ignored: no queueing, and the latched fields are not disturbed.
- Opcode classes and values: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, NEG 01001, NOT 01010, MUL 01110, DIV 01111. All other values are illegal.

## Timing
- All outputs decode from registered state and latched fields. They change only after a rising Clock edge and are stable across the falling edge.
- start is accepted at edge k; the first strobe cycle begins at k.
- Cycles from acceptance to done (inclusive):
  - binary: 4
  - unary: 3
  - MUL/DIV: 5
  - illegal: 1
- Back-to-back: start may be asserted in the IDLE cycle right after DONE. Minimum issue interval is latency + 1.
- Reset values (clear=1 at any edge, including mid-instruction): state IDLE, ready=1, and every other output 0 in the following cycle. No partial writeback completes after clear.
- clear has priority over start in the same cycle.

## Configuration
- ALU_SEQ_MULDIV_EN defined: MUL/DIV are supported and use T_ZHI, with LO then HI writeback.
- ALU_SEQ_MULDIV_EN undefined:
  - MUL and DIV are illegal; T_ZHI, HIin and LOin logic is removed.
  - HIin and LOin are tied to 0.

## Structure
- Shared package alu_seq_pkg holds:
  - the state enum
  - opcode localparams, including OP_NEG = 5'b01001, which matches the existing datapath encoding
  - op-class functions: is_unary, is_muldiv, is_legal
- One sub-module, reg_onehot_dec (4-to-16 decoder with enable). It is instantiated twice, for Rout and Rin.

## Test plan
- ADD: R2=5, R3=12; start op=00011, ra=1, rb=2, rc=3.
  - T_Y: Rout=16'h0004 and Yin=1.
  - T_EXEC: Rout=16'h0008.
  - T_ZLO: Rin=16'h0002.
  - done in the 4th cycle; R1=17.
- NEG: R2=5; op=01001, ra=1, rb=2. No Yin cycle; R1=32'hFFFFFFFB; done in the 3rd cycle.
- MUL (with ALU_SEQ_MULDIV_EN): R2=32'h00010000, R3=32'h00010000. LO=0 then HI=1; done in the 5th cycle; no Rin pulse.
- Illegal op=11111: done=1 and illegal=1 in the 1st cycle; Rin, Yin and Z strobes stay 0 throughout.
- start re-asserted during T_EXEC with different fields: ignored, and the original instruction completes unchanged.
- clear asserted during T_EXEC of an ADD: next cycle in IDLE with all strobes 0, R1 unchanged; a new start is accepted the cycle after.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared state enum, opcode encodings and op-class helpers for alu_op_sequencer.
// Build option ALU_SEQ_MULDIV_EN makes MUL/DIV legal; otherwise they decode as illegal.
package alu_seq_pkg;

  localparam int OP_W  = 5;
  localparam int REG_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T_Y    = 3'd1,
    S_T_EXEC = 3'd2,
    S_T_ZLO  = 3'd3,
    S_T_ZHI  = 3'd4,
    S_DONE   = 3'd5
  } alu_seq_state_e;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHL = 5'b01000;
  localparam logic [OP_W-1:0] OP_NEG = 5'b01001;  // matches existing datapath encoding
  localparam logic [OP_W-1:0] OP_NOT = 5'b01010;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV = 5'b01111;

  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_NEG, OP_NOT: legal = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
      OP_MUL, OP_DIV: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// 4-to-16 one-hot register select decoder; all-zero output when disabled.
module reg_onehot_dec
  import alu_seq_pkg::*;
(
  input  logic               en_i,
  input  logic [REG_W-1:0]   sel_i,
  output logic [15:0]        onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Strobe sequencer for register-to-register ALU instructions of the mini CPU datapath.
// ALU_SEQ_MULDIV_EN adds the T_ZHI step with LO-then-HI writeback for MUL/DIV.
//
// Handshake: start is taken on a rising edge only while ready=1 (IDLE); the fields
// are latched on that edge and starts in any other state are dropped, not queued.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic               Clock,
  input  logic               clear,
  input  logic               start,
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   ra,
  input  logic [REG_W-1:0]   rb,
  input  logic [REG_W-1:0]   rc,
  output logic               ready,
  output logic               done,
  output logic               illegal,
  output logic [OP_W-1:0]    alu_op,
  output logic [15:0]        Rout,
  output logic [15:0]        Rin,
  output logic               Yin,
  output logic               ZHighin,
  output logic               Zlowin,
  output logic               Zlowout,
  output logic               Zhighout,
  output logic               HIin,
  output logic               LOin,
  output alu_seq_state_e     state_dbg
);

  alu_seq_state_e   state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic [REG_W-1:0] ra_q, rb_q, rc_q;
  logic             illegal_q;
  logic             accept;

  logic             rout_en, rin_en;
  logic [REG_W-1:0] rout_sel, rin_sel;

  assign accept    = (state_q == S_IDLE) && start;
  assign state_dbg = state_q;

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op;
        ra_q      <= ra;
        rb_q      <= rb;
        rc_q      <= rc;
        illegal_q <= !is_legal(op);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    alu_op   = '0;
    rout_en  = 1'b0;
    rout_sel = rb_q;
    rin_en   = 1'b0;
    rin_sel  = ra_q;
    Yin      = 1'b0;
    ZHighin  = 1'b0;
    Zlowin   = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (!is_legal(op))    state_d = S_DONE;
          else if (is_unary(op)) state_d = S_T_EXEC;
          else                   state_d = S_T_Y;
        end
      end
      S_T_Y: begin
        rout_en = 1'b1;
        Yin     = 1'b1;
        state_d = S_T_EXEC;
      end
      S_T_EXEC: begin
        // Unary ops take their only operand from rb straight onto the bus.
        rout_en  = 1'b1;
        rout_sel = is_unary(op_q) ? rb_q : rc_q;
        ZHighin  = 1'b1;
        Zlowin   = 1'b1;
        alu_op   = op_q;
        state_d  = S_T_ZLO;
      end
      S_T_ZLO: begin
        Zlowout = 1'b1;
        alu_op  = op_q;
        state_d = S_DONE;
`ifdef ALU_SEQ_MULDIV_EN
        if (is_muldiv(op_q)) begin
          LOin    = 1'b1;
          state_d = S_T_ZHI;
        end else
`endif
        begin
          rin_en = 1'b1;
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_T_ZHI: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        alu_op   = op_q;
        state_d  = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        illegal = illegal_q;
        alu_op  = illegal_q ? '0 : op_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  reg_onehot_dec u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (Rout)
  );

  reg_onehot_dec u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (rin_sel),
    .onehot_o (Rin)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: per-cycle strobe vectors from an op-class model, plus a
// small register-file/ALU datapath model driven by the DUT strobes to check results.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct packed {
    logic        ready, done, illegal;
    logic [4:0]  alu_op;
    logic [15:0] rout, rin;
    logic        yin, zhin, zlin, zlout, zhout, hiin, loin;
  } vec_t;
  localparam int VW = $bits(vec_t);

  typedef struct {
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int         lat;
    bit         ill;
  } tv_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk, s_clear, s_start;
  logic [4:0] s_op;
  logic [3:0] s_ra, s_rb, s_rc;
  logic w_ready, w_done, w_illegal, w_yin, w_zhin, w_zlin, w_zlout, w_zhout, w_hiin, w_loin;
  logic [4:0] w_alu_op;
  logic [15:0] w_rout, w_rin;
  alu_seq_state_e w_state;
  vec_t act_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  alu_op_sequencer dut (
    .Clock(clk), .clear(s_clear), .start(s_start), .op(s_op),
    .ra(s_ra), .rb(s_rb), .rc(s_rc),
    .ready(w_ready), .done(w_done), .illegal(w_illegal), .alu_op(w_alu_op),
    .Rout(w_rout), .Rin(w_rin), .Yin(w_yin), .ZHighin(w_zhin), .Zlowin(w_zlin),
    .Zlowout(w_zlout), .Zhighout(w_zhout), .HIin(w_hiin), .LOin(w_loin),
    .state_dbg(w_state)
  );

  assign act_v = {w_ready, w_done, w_illegal, w_alu_op, w_rout, w_rin,
                  w_yin, w_zhin, w_zlin, w_zlout, w_zhout, w_hiin, w_loin};

  // ---------------- datapath model ----------------
  logic [31:0] rf[16];
  logic [31:0] pre_rf[16];
  logic [31:0] y, hi, lo;
  logic [63:0] z;
  logic        do_preset;

  function automatic logic [63:0] alu_fn(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    case (o)
      5'd3:  r = {32'h0, a + b};
      5'd4:  r = {32'h0, a - b};
      5'd5:  r = {32'h0, a & b};
      5'd6:  r = {32'h0, a | b};
      5'd7:  r = {32'h0, a >> b[4:0]};
      5'd8:  r = {32'h0, a << b[4:0]};
      5'd9:  r = {32'h0, 32'h0 - b};
      5'd10: r = {32'h0, ~b};
      5'd14: r = {32'h0, a} * {32'h0, b};
      5'd15: if (b != 0) r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int oh_idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : dp_model
    logic [31:0] bus;
    int ri, wi;
    ri = oh_idx(w_rout);
    wi = oh_idx(w_rin);
    if (ri >= 0)      bus = rf[ri];
    else if (w_zlout) bus = z[31:0];
    else if (w_zhout) bus = z[63:32];
    else              bus = '0;
    if (do_preset) begin
      rf <= pre_rf;
      hi <= '0;
      lo <= '0;
    end else begin
      if (w_yin)  y  <= bus;
      if (w_zlin) z  <= alu_fn(w_alu_op, y, bus);
      if (wi >= 0) rf[wi] <= bus;
      if (w_loin) lo <= bus;
      if (w_hiin) hi <= bus;
    end
  end

  // ---------------- op-class reference model ----------------
  function automatic bit tb_unary(input logic [4:0] o);  return (o == 5'd9) || (o == 5'd10); endfunction
  function automatic bit tb_muldiv(input logic [4:0] o); return (o == 5'd14) || (o == 5'd15); endfunction
  function automatic bit tb_legal(input logic [4:0] o);
    return (o >= 5'd3 && o <= 5'd10) || (MD && tb_muldiv(o));
  endfunction

  function automatic vec_t idle_vec();
    vec_t v;
    v = '0;
    v.ready = 1'b1;
    return v;
  endfunction

  logic [VW-1:0] exp_q[$];

  // Expected strobe vector for each cycle from acceptance through done.
  task automatic build_exp(input logic [4:0] o, input logic [3:0] a, b, c);
    vec_t v;
    exp_q.delete();
    if (!tb_legal(o)) begin
      v = '0; v.done = 1'b1; v.illegal = 1'b1;
      exp_q.push_back(v);
      return;
    end
    if (!tb_unary(o)) begin
      v = '0; v.rout = 16'd1 << b; v.yin = 1'b1;
      exp_q.push_back(v);
    end
    v = '0; v.rout = 16'd1 << (tb_unary(o) ? b : c); v.zhin = 1'b1; v.zlin = 1'b1; v.alu_op = o;
    exp_q.push_back(v);
    v = '0; v.zlout = 1'b1; v.alu_op = o;
    if (tb_muldiv(o)) v.loin = 1'b1;
    else              v.rin = 16'd1 << a;
    exp_q.push_back(v);
    if (tb_muldiv(o)) begin
      v = '0; v.zhout = 1'b1; v.hiin = 1'b1; v.alu_op = o;
      exp_q.push_back(v);
    end
    v = '0; v.done = 1'b1; v.alu_op = o;
    exp_q.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preset_regs();
    do_preset = 1'b1;
    @(negedge clk);
    do_preset = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic issue(input logic [4:0] o, input logic [3:0] a, b, c, input bit disturb,
                       output int lat, output bit ill);
    int n;
    build_exp(o, a, b, c);
    n   = exp_q.size();
    lat = 0;
    ill = 1'b0;
    s_start = 1'b1; s_op = o; s_ra = a; s_rb = b; s_rc = c;
    @(negedge clk);
    s_start = 1'b0;
    s_op = 5'($urandom_range(0, 31));
    s_ra = 4'($urandom_range(0, 15)); s_rb = 4'($urandom_range(0, 15)); s_rc = 4'($urandom_range(0, 15));
    for (int k = 0; k < n; k++) begin
      if (w_done && lat == 0) lat = k + 1;
      if (w_illegal) ill = 1'b1;
      chk($sformatf("strobes op=%0h cyc%0d", o, k), act_v, exp_q.pop_front());
      if (disturb && k == 1) begin
        s_start = 1'b1; s_op = 5'd4; s_ra = ~a; s_rb = ~b; s_rc = ~c;
      end
      if (disturb && k == 2) s_start = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("idle_after op=%0h", o), act_v, idle_vec());
  endtask

  // Issue one instruction and check the datapath result against plain arithmetic.
  task automatic run_checked(input logic [4:0] o, input logic [3:0] a, b, c, input bit disturb,
                             output int lat, output bit ill);
    logic [31:0] pre[16];
    logic [63:0] r;
    pre = rf;
    issue(o, a, b, c, disturb, lat, ill);
    if (!tb_legal(o)) begin
      chk("illegal_no_wb", rf[a], pre[a]);
    end else if (tb_muldiv(o)) begin
      r = alu_fn(o, pre[b], pre[c]);
      chk("muldiv_lo", lo, r[31:0]);
      chk("muldiv_hi", hi, r[63:32]);
      chk("muldiv_no_rin", rf[a], pre[a]);
    end else if (tb_unary(o)) begin
      r = alu_fn(o, 32'h0, pre[b]);
      chk("unary_wb", rf[a], r[31:0]);
    end else begin
      r = alu_fn(o, pre[b], pre[c]);
      chk("binary_wb", rf[a], r[31:0]);
    end
  endtask

  function automatic int exp_lat(input logic [4:0] o);
    if (!tb_legal(o)) return 1;
    if (tb_muldiv(o)) return 5;
    if (tb_unary(o))  return 3;
    return 4;
  endfunction

  // ---------------- test sequence ----------------
  tv_t tv[14];
  logic [4:0] legal_ops[10];

  initial begin
    int lat;
    bit ill;
    logic [4:0] o;

    tv[0]  = '{5'b00011, 4'd1, 4'd2, 4'd3, 4, 1'b0};
    tv[1]  = '{5'b00100, 4'd4, 4'd5, 4'd6, 4, 1'b0};
    tv[2]  = '{5'b00101, 4'd7, 4'd8, 4'd9, 4, 1'b0};
    tv[3]  = '{5'b00110, 4'd0, 4'd15, 4'd1, 4, 1'b0};
    tv[4]  = '{5'b00111, 4'd10, 4'd11, 4'd12, 4, 1'b0};
    tv[5]  = '{5'b01000, 4'd13, 4'd14, 4'd2, 4, 1'b0};
    tv[6]  = '{5'b01001, 4'd1, 4'd2, 4'd7, 3, 1'b0};
    tv[7]  = '{5'b01010, 4'd3, 4'd3, 4'd0, 3, 1'b0};
    tv[8]  = '{5'b01110, 4'd5, 4'd2, 4'd3, MD ? 5 : 1, !MD};
    tv[9]  = '{5'b01111, 4'd6, 4'd4, 4'd9, MD ? 5 : 1, !MD};
    tv[10] = '{5'b11111, 4'd1, 4'd2, 4'd3, 1, 1'b1};
    tv[11] = '{5'b00000, 4'd2, 4'd3, 4'd4, 1, 1'b1};
    tv[12] = '{5'b01011, 4'd8, 4'd8, 4'd8, 1, 1'b1};
    tv[13] = '{5'b00011, 4'd5, 4'd5, 4'd5, 4, 1'b0};
    legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15};

    s_clear = 1'b1; s_start = 1'b0; s_op = '0; s_ra = '0; s_rb = '0; s_rc = '0;
    do_preset = 1'b0;
    for (int i = 0; i < 16; i++) pre_rf[i] = $urandom();
    repeat (2) @(negedge clk);
    chk("reset_outputs", act_v, idle_vec());
    chk("reset_state", 64'(w_state), 64'(S_IDLE));

    // clear wins over start on the same edge
    s_start = 1'b1; s_op = 5'd3;
    @(negedge clk);
    chk("clear_over_start", act_v, idle_vec());
    s_clear = 1'b0; s_start = 1'b0;
    preset_regs();

    // table-driven vectors, issued back to back
    for (int i = 0; i < 14; i++) begin
      run_checked(tv[i].op, tv[i].ra, tv[i].rb, tv[i].rc, 1'b0, lat, ill);
      chk($sformatf("latency tv%0d", i), 64'(lat), 64'(tv[i].lat));
      chk($sformatf("illegal tv%0d", i), 64'(ill), 64'(tv[i].ill));
    end

    // ADD: R1 = R2 + R3 = 17
    pre_rf[1] = 32'h0; pre_rf[2] = 32'd5; pre_rf[3] = 32'd12;
    preset_regs();
    run_checked(5'b00011, 4'd1, 4'd2, 4'd3, 1'b0, lat, ill);
    chk("add_r1", rf[1], 32'd17);

    // NEG: R1 = -5
    run_checked(5'b01001, 4'd1, 4'd2, 4'd0, 1'b0, lat, ill);
    chk("neg_r1", rf[1], 32'hFFFFFFFB);
    chk("neg_lat", 64'(lat), 64'd3);

`ifdef ALU_SEQ_MULDIV_EN
    pre_rf[2] = 32'h00010000; pre_rf[3] = 32'h00010000;
    preset_regs();
    run_checked(5'b01110, 4'd1, 4'd2, 4'd3, 1'b0, lat, ill);
    chk("mul_lo", lo, 32'h0);
    chk("mul_hi", hi, 32'h1);
    chk("mul_lat", 64'(lat), 64'd5);
`endif

    // start during T_EXEC must be ignored
    pre_rf[1] = 32'h0; pre_rf[2] = 32'd5; pre_rf[3] = 32'd12;
    preset_regs();
    run_checked(5'b00011, 4'd1, 4'd2, 4'd3, 1'b1, lat, ill);
    chk("disturb_r1", rf[1], 32'd17);
    chk("disturb_lat", 64'(lat), 64'd4);

    // clear during T_EXEC aborts without writeback
    pre_rf[1] = 32'hAA;
    preset_regs();
    s_start = 1'b1; s_op = 5'd3; s_ra = 4'd1; s_rb = 4'd2; s_rc = 4'd3;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    chk("clr_pre_state", 64'(w_state), 64'(S_T_EXEC));
    s_clear = 1'b1;
    @(negedge clk);
    s_clear = 1'b0;
    chk("clr_idle", act_v, idle_vec());
    chk("clr_r1_kept", rf[1], 32'hAA);
    run_checked(5'b00011, 4'd1, 4'd2, 4'd3, 1'b0, lat, ill);
    chk("clr_restart_lat", 64'(lat), 64'd4);
    chk("clr_restart_r1", rf[1], 32'd17);

    // randomized instructions against the model
    for (int i = 0; i < 16; i++) pre_rf[i] = $urandom();
    preset_regs();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) o = legal_ops[$urandom_range(0, 9)];
      else                           o = 5'($urandom_range(0, 31));
      run_checked(o, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), lat, ill);
      chk($sformatf("rand_lat%0d", i), 64'(lat), 64'(exp_lat(o)));
      chk($sformatf("rand_ill%0d", i), 64'(ill), 64'(!tb_legal(o)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
